// File: rtl/alu_dispatch.sv
// Issue-side sequencer for a combinational multicycle ALU: accepts requests, holds
// registered operands for a per-op latency, and queues tagged results in a 2-entry FIFO.
module alu_dispatch #(
  parameter int TAG_W      = 4,
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MUL    = 3,
  parameter int LAT_DBL    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_floating,
  input  logic             req_form,
  input  logic [1:0]       req_precision,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [31:0]      req_c,
  input  logic [31:0]      req_d,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       alu_op,
  output logic             alu_floating,
  output logic             alu_form,
  output logic [1:0]       alu_precision,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [31:0]      alu_c,
  output logic [31:0]      alu_d,
  input  logic [31:0]      alu_y1,
  input  logic [31:0]      alu_y2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y1,
  output logic [31:0]      rsp_y2,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int MAX_L = ((LAT_MUL > LAT_SIMPLE) ? LAT_MUL : LAT_SIMPLE) + LAT_DBL;
  localparam int CNT_W = (MAX_L < 2) ? 1 : $clog2(MAX_L + 1);

  typedef enum logic { IDLE, EXEC } state_t;

  typedef struct packed {
    logic [31:0]      y1;
    logic [31:0]      y2;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat;
  logic [TAG_W-1:0] tag_q;
  logic             last, accept, push, pop;
  logic [1:0]       count;
  logic [2:0]       space;
  logic             wr_ptr, rd_ptr;
  rsp_t             fifo_q [2];
  rsp_t             head;

  always_comb begin
    lat = (req_op == 3'b010 || req_op == 3'b110) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_SIMPLE);
    if (req_precision == 2'b11) lat = lat + CNT_W'(LAT_DBL);
  end

  assign last   = (state == EXEC) && (cnt == CNT_W'(1));
  assign pop    = rsp_valid && rsp_ready;
  assign push   = last;
  // A pop on the same edge frees a slot, so back-to-back issue can use it.
  assign space  = 3'd2 - {1'b0, count} + {2'b0, pop};
  assign req_ready = ((state == IDLE) && (space >= 3'd1)) ||
                     (last && (space >= 3'd2));
  assign accept = req_valid && req_ready;
  assign busy   = (state == EXEC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: if (last)   state_nxt = accept ? EXEC : IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= lat;
      else if (state == EXEC)
        cnt <= cnt - CNT_W'(1);
    end
  end

  // Operands only move on accept; they are a multicycle path into the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_op        <= '0;
      alu_floating  <= 1'b0;
      alu_form      <= 1'b0;
      alu_precision <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_c         <= '0;
      alu_d         <= '0;
      tag_q         <= '0;
    end else if (accept) begin
      alu_op        <= req_op;
      alu_floating  <= req_floating;
      alu_form      <= req_form;
      alu_precision <= req_precision;
      alu_a         <= req_a;
      alu_b         <= req_b;
      alu_c         <= req_c;
      alu_d         <= req_d;
      tag_q         <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{y1: alu_y1, y2: alu_y2, tag: tag_q};
  end

  assign head      = fifo_q[rd_ptr];
  assign rsp_valid = (count != 2'd0);
  assign rsp_y1    = rsp_valid ? head.y1  : '0;
  assign rsp_y2    = rsp_valid ? head.y2  : '0;
  assign rsp_tag   = rsp_valid ? head.tag : '0;

endmodule
